// File: rtl/cmplx_mult_pipe.sv
// cmplx_mult_pipe: three-stage pipelined signed fixed-point complex multiplier
// (Qm.FRAC) computing a*b or a*conj(b), with round-half-up to FRAC bits.
//
// Optional build macro: CMULT_SAT_EN
//   defined   - out-of-range components clamp to the WIDTH-bit signed limits
//   undefined - out-of-range components wrap (low WIDTH bits kept)
//   out_ovf flags the out-of-range condition in both builds.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   inp_a_re/inp_a_im        operand a
//   inp_b_re/inp_b_im        operand b (twiddle)
//   inp_conj                 1: multiply by conj(b)
//   inp_stb / inp_ack        input handshake (inp_ack = ~stall, combinational)
//   out_re/out_im/out_ovf    registered result and overflow flag
//   out_stb / out_ack        output handshake
module cmplx_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inp_a_re,
    input  logic [WIDTH-1:0] inp_a_im,
    input  logic [WIDTH-1:0] inp_b_re,
    input  logic [WIDTH-1:0] inp_b_im,
    input  logic             inp_conj,
    input  logic             inp_stb,
    output logic             inp_ack,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_ovf,
    output logic             out_stb,
    input  logic             out_ack
);

    localparam int unsigned PW = unsigned'(2 * WIDTH + 1);   // product width
    localparam int unsigned SW = unsigned'(2 * WIDTH + 2);   // sum width
    localparam int unsigned TW = SW - unsigned'(WIDTH) + 1;  // bits that must agree in range
    localparam logic signed [SW-1:0] RND   = SW'(1) << (FRAC - 1);
    localparam logic [WIDTH-1:0]     MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    // Value fits in WIDTH signed bits iff its top TW bits are all equal.
    function automatic logic out_of_range(input logic [TW-1:0] top);
        return !((&top) | ~(|top));
    endfunction

    logic stall;
    assign stall   = out_stb & ~out_ack;
    assign inp_ack = ~stall;

    // Conjugate negation happens one bit wider so -(-2^(WIDTH-1)) is representable.
    logic signed [WIDTH:0] bi_ext, bi_sel;
    assign bi_ext = $signed({inp_b_im[WIDTH-1], inp_b_im});
    assign bi_sel = inp_conj ? -bi_ext : bi_ext;

    logic                    v1, v2;
    logic signed [WIDTH-1:0] s1_ar, s1_ai, s1_br;
    logic signed [WIDTH:0]   s1_bi;
    logic signed [PW-1:0]    s2_rr, s2_ii, s2_ri, s2_ir;

    // Stage 3 arithmetic: sum, round, shift, range check, reduce.
    logic signed [SW-1:0] sum_re, sum_im, sh_re, sh_im;
    logic                 ovf_re, ovf_im;
    logic [WIDTH-1:0]     res_re, res_im;

    assign sum_re = SW'(s2_rr) - SW'(s2_ii);
    assign sum_im = SW'(s2_ri) + SW'(s2_ir);
    assign sh_re  = (sum_re + RND) >>> FRAC;
    assign sh_im  = (sum_im + RND) >>> FRAC;

    always_comb begin
        ovf_re = out_of_range(sh_re[SW-1:WIDTH-1]);
        ovf_im = out_of_range(sh_im[SW-1:WIDTH-1]);
`ifdef CMULT_SAT_EN
        res_re = ovf_re ? (sh_re[SW-1] ? MIN_V : MAX_V) : sh_re[WIDTH-1:0];
        res_im = ovf_im ? (sh_im[SW-1] ? MIN_V : MAX_V) : sh_im[WIDTH-1:0];
`else
        res_re = sh_re[WIDTH-1:0];
        res_im = sh_im[WIDTH-1:0];
`endif
    end

    // Pipeline registers: everything advances unless the output is stalled,
    // so empty stages are always refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            out_stb <= 1'b0;
            s1_ar   <= '0;
            s1_ai   <= '0;
            s1_br   <= '0;
            s1_bi   <= '0;
            s2_rr   <= '0;
            s2_ii   <= '0;
            s2_ri   <= '0;
            s2_ir   <= '0;
            out_re  <= '0;
            out_im  <= '0;
            out_ovf <= 1'b0;
        end else if (!stall) begin
            v1      <= inp_stb;
            v2      <= v1;
            out_stb <= v2;
            if (inp_stb) begin
                s1_ar <= $signed(inp_a_re);
                s1_ai <= $signed(inp_a_im);
                s1_br <= $signed(inp_b_re);
                s1_bi <= bi_sel;
            end
            if (v1) begin
                s2_rr <= PW'(s1_ar) * PW'(s1_br);
                s2_ii <= PW'(s1_ai) * PW'(s1_bi);
                s2_ri <= PW'(s1_ar) * PW'(s1_bi);
                s2_ir <= PW'(s1_ai) * PW'(s1_br);
            end
            if (v2) begin
                out_re  <= res_re;
                out_im  <= res_im;
                out_ovf <= ovf_re | ovf_im;
            end
        end
    end

endmodule
